diagv2_test_sequencer: RTL
==========================

Name: diagv2_test_sequencer

Overview:
Synthesizable campaign controller for the single-cycle diagv2 core.
- Steps through NUM_TESTS program/data image pairs: requests each image load, holds core reset, runs the core, and halts it on ecall.
- Classifies each result by the x10 status code and keeps pass/fail tallies.
- Sits beside diagv2_top on FPGA/board builds; owns core reset, core clock-enable and the image-bank index.

Parameters:
NUM_TESTS, 50, number of test image pairs in the campaign
IDX_W, 6, width of test index (ceil(log2(NUM_TESTS)))
CNT_W, 7, width of pass/fail counters (holds NUM_TESTS)
RESET_CYCLES, 2, core reset hold cycles after load (>=1)
TIMEOUT_CYCLES, 4096, watchdog limit in RUN (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; one clock domain only
start  in  1  pulse; begins campaign from IDLE or DONE, ignored otherwise
load_req  out  1  request loader to fill imem/dmem for test_idx
load_done  in  1  one-cycle loader acknowledge
test_idx  out  IDX_W  current test / image-bank select
core_reset  out  1  drives diagv2_top reset
core_clk_en  out  1  core clock enable (0 = core frozen)
ecall  in  1  core ecall indication
status_code  in  `DataBusBits  core x10
last_status  out  `DataBusBits  status captured for the last finished test
result_valid  out  1  one-cycle pulse per finished test
result_pass  out  1  pass flag, valid with result_valid
passed  out  CNT_W  passed-test count
failed  out  CNT_W  failed-test count
busy  out  1  high in LOAD/RST/RUN/RECORD
done  out  1  high in DONE

Behaviour:
- Reset values: state=IDLE; test_idx=0; passed=failed=0; last_status=0; load_req=0; core_reset=1; core_clk_en=0; result_valid=0; result_pass=0; done=0; busy=0.
- IDLE: core_reset=1, core_clk_en=0. start -> LOAD. Clear passed/failed and set test_idx=0 on the same edge.
- LOAD: load_req=1 (registered) from the first LOAD cycle until the load_done cycle; core_reset=1, core_clk_en=0. load_done -> RST. load_done outside LOAD is ignored.
- RST: core_reset=1, core_clk_en=1 for exactly RESET_CYCLES cycles (down-counter), then -> RUN.
- RUN: core_reset=0.
  - core_clk_en = !ecall, combinational, so the core freezes in the ecall cycle.
  - ecall sampled high: capture status_code into last_status, -> RECORD.
- RECORD (1 cycle): core_clk_en=0, core_reset=0.
  - result_valid=1; result_pass=(last_status==0).
  - Increment passed if last_status==0, else failed.
  - If test_idx==NUM_TESTS-1 -> DONE, else test_idx+1 and -> LOAD.
- DONE: done=1, core_reset=1, core_clk_en=0, tallies held. start -> LOAD with tallies cleared and test_idx=0.
- start while busy: ignored. Reset mid-campaign: IDLE next cycle, all outputs take their reset values, partial tallies lost.
- Counters never wrap: passed+failed <= NUM_TESTS by construction.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a watchdog counts RUN cycles, cleared on RUN entry. If the count reaches TIMEOUT_CYCLES-1 with ecall low, last_status is set to all-ones and the FSM goes to RECORD, which counts a failure. If ecall and the terminal count coincide, ecall wins and status_code is captured.
- Undefined: no watchdog; RUN waits for ecall indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Add to diagv2_const.vh:
  - state encodings `SEQ_IDLE, `SEQ_LOAD, `SEQ_RST, `SEQ_RUN, `SEQ_RECORD, `SEQ_DONE (3 bits)
  - `SEQ_TIMEOUT_STATUS (all-ones, `DataBusBits wide)
  - `DataBusBits is reused as is.
- One sub-module: diagv2_seq_watchdog (clear, enable, terminal-count output), instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- NUM_TESTS=3, RESET_CYCLES=2; start; load_done 4 cycles after each load_req; ecall with status 0 after 10 RUN cycles -> three result_valid pulses, passed=3, failed=0, done=1, test_idx=2. core_reset high exactly 2 cycles with core_clk_en=1 before each RUN.
- Status codes 0, 5, 0 -> passed=2, failed=1; last_status=5 and result_pass=0 on the second pulse.
- ecall in RUN -> core_clk_en low in the same cycle; core_clk_en=0 in RECORD; load_req rises the next cycle.
- start pulsed during RUN -> no effect. reset asserted during RUN of test 1 -> IDLE next cycle, passed=failed=0, core_reset=1, test_idx=0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ecall -> RECORD after 16 RUN cycles, last_status=all-ones, failed=1. ecall on the terminal cycle with status 0 -> passed=1.
- From DONE, start -> tallies cleared, test_idx=0, load_req=1 on the next cycle.

Source files
------------

// File: rtl/diagv2_test_sequencer_pkg.sv
// Shared types and constants for the diagv2 test campaign sequencer.
// Optional watchdog build macro: SEQ_TIMEOUT_EN.
package diagv2_test_sequencer_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LOAD   = 3'd1,
        SEQ_RST    = 3'd2,
        SEQ_RUN    = 3'd3,
        SEQ_RECORD = 3'd4,
        SEQ_DONE   = 3'd5
    } seq_state_e;

    // Status reported for a test that never reached ecall.
    localparam logic [DATA_W-1:0] SEQ_TIMEOUT_STATUS = '1;

endpackage

// File: rtl/diagv2_seq_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the terminal count.
// Instantiated by the sequencer only when SEQ_TIMEOUT_EN is defined.
module diagv2_seq_watchdog #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/diagv2_test_sequencer.sv
// Campaign controller: load image, hold core reset, run to ecall, tally result.
// Define SEQ_TIMEOUT_EN to add a RUN-phase watchdog (diagv2_seq_watchdog).
module diagv2_test_sequencer
    import diagv2_test_sequencer_pkg::*;
#(
    parameter int unsigned NUM_TESTS      = 50,
    parameter int unsigned IDX_W          = 6,
    parameter int unsigned CNT_W          = 7,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              load_req,
    input  logic              load_done,
    output logic [IDX_W-1:0]  test_idx,
    output logic              core_reset,
    output logic              core_clk_en,
    input  logic              ecall,
    input  logic [DATA_W-1:0] status_code,
    output logic [DATA_W-1:0] last_status,
    output logic              result_valid,
    output logic              result_pass,
    output logic [CNT_W-1:0]  passed,
    output logic [CNT_W-1:0]  failed,
    output logic              busy,
    output logic              done
);

    localparam int unsigned RST_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;

    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("diagv2_test_sequencer: RESET_CYCLES must be >=1 and TIMEOUT_CYCLES >=2");
    end

    seq_state_e        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [IDX_W-1:0]  test_idx_d;
    logic [CNT_W-1:0]  passed_d, failed_d;
    logic [DATA_W-1:0] last_status_d;
    logic              clk_en_q, clk_en_d;
    logic              load_req_d, core_reset_d, result_valid_d, result_pass_d;
    logic              busy_d, done_d;
    logic              timeout_c;

`ifdef SEQ_TIMEOUT_EN
    diagv2_seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q != SEQ_RUN),
        .enable    (state_q == SEQ_RUN),
        .terminal_c(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state, datapath updates and next-cycle output decode.
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        test_idx_d     = test_idx;
        passed_d       = passed;
        failed_d       = failed;
        last_status_d  = last_status;
        result_pass_d  = 1'b0;

        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (start) begin
                    state_d    = SEQ_LOAD;
                    test_idx_d = '0;
                    passed_d   = '0;
                    failed_d   = '0;
                end
            end
            SEQ_LOAD: begin
                if (load_done) begin
                    state_d   = SEQ_RST;
                    rst_cnt_d = RST_W'(RESET_CYCLES - 1);
                end
            end
            SEQ_RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = SEQ_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            SEQ_RUN: begin
                // ecall takes priority over a coinciding watchdog expiry.
                if (ecall) begin
                    state_d       = SEQ_RECORD;
                    last_status_d = status_code;
                    result_pass_d = (status_code == '0);
                end else if (timeout_c) begin
                    state_d       = SEQ_RECORD;
                    last_status_d = SEQ_TIMEOUT_STATUS;
                end
            end
            SEQ_RECORD: begin
                if (last_status == '0) begin
                    passed_d = passed + CNT_W'(1);
                end else begin
                    failed_d = failed + CNT_W'(1);
                end
                if (test_idx == IDX_W'(NUM_TESTS - 1)) begin
                    state_d = SEQ_DONE;
                end else begin
                    state_d    = SEQ_LOAD;
                    test_idx_d = test_idx + IDX_W'(1);
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        load_req_d     = (state_d == SEQ_LOAD);
        core_reset_d   = (state_d inside {SEQ_IDLE, SEQ_LOAD, SEQ_RST, SEQ_DONE});
        clk_en_d       = (state_d inside {SEQ_RST, SEQ_RUN});
        result_valid_d = (state_d == SEQ_RECORD);
        busy_d         = (state_d inside {SEQ_LOAD, SEQ_RST, SEQ_RUN, SEQ_RECORD});
        done_d         = (state_d == SEQ_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            rst_cnt_q    <= '0;
            test_idx     <= '0;
            passed       <= '0;
            failed       <= '0;
            last_status  <= '0;
            load_req     <= 1'b0;
            core_reset   <= 1'b1;
            clk_en_q     <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            test_idx     <= test_idx_d;
            passed       <= passed_d;
            failed       <= failed_d;
            last_status  <= last_status_d;
            load_req     <= load_req_d;
            core_reset   <= core_reset_d;
            clk_en_q     <= clk_en_d;
            result_valid <= result_valid_d;
            result_pass  <= result_pass_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Freeze the core in the very cycle it raises ecall.
    assign core_clk_en = clk_en_q && !((state_q == SEQ_RUN) && ecall);

endmodule
